// File: rtl/dmi_pkg.sv
// Shared constants and state encoding for the DMI core-clock endpoint.
package dmi_pkg;

    localparam int unsigned ADDR_BITS = 6;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned OP_BITS   = 2;
    localparam int unsigned REQ_BITS  = ADDR_BITS + DATA_BITS + OP_BITS;

    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned DATA_LSB = 2;
    localparam int unsigned ADDR_LSB = 34;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] STS_OK   = 2'd0;
    localparam logic [1:0] STS_FAIL = 2'd2;
    localparam logic [1:0] STS_BUSY = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK_WAIT,
        ST_ACCESS,
        ST_RESP,
        ST_RESP_DONE
    } state_t;

endpackage

// File: rtl/dmi_slave_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dmi_slave.sv
// DMI endpoint: accepts DTM requests over a four-phase handshake, runs one
// debug-module bus access and returns the response over a second handshake.
module dmi_slave
    import dmi_pkg::*;
#(
    parameter int unsigned DMI_ADDR_BITS  = ADDR_BITS,
    parameter int unsigned DMI_DATA_BITS  = DATA_BITS,
    parameter int unsigned DMI_OP_BITS    = OP_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           dtm_req_i,
    input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_i,
    output logic                                           dm_ack_o,
    output logic                                           dm_resp_o,
    output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_o,
    input  logic                                           dtm_ack_i,
    output logic                                           dmi_valid_o,
    output logic                                           dmi_we_o,
    output logic [DMI_ADDR_BITS-1:0]                       dmi_addr_o,
    output logic [DMI_DATA_BITS-1:0]                       dmi_wdata_o,
    input  logic                                           dmi_ready_i,
    input  logic [DMI_DATA_BITS-1:0]                       dmi_rdata_i,
    input  logic                                           dmi_err_i
);

    localparam int unsigned REQ_W    = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LAST_I   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [31:0] LAST_V   = LAST_I;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_V[CNT_W-1:0];
    localparam int unsigned A_LSB    = DMI_DATA_BITS + DMI_OP_BITS;

    logic w_req_s;
    logic w_ack_s;

    sync_2ff u_req_sync (.i_clk(clk), .i_rst(rst), .i_d(dtm_req_i), .o_q(w_req_s));
    sync_2ff u_ack_sync (.i_clk(clk), .i_rst(rst), .i_d(dtm_ack_i), .o_q(w_ack_s));

    state_t                    r_state,     w_state_nxt;
    logic [DMI_ADDR_BITS-1:0]  r_addr,      w_addr_nxt;
    logic [DMI_DATA_BITS-1:0]  r_wdata,     w_wdata_nxt;
    logic [DMI_OP_BITS-1:0]    r_op,        w_op_nxt;
    logic                      r_ack,       w_ack_nxt;
    logic                      r_valid,     w_valid_nxt;
    logic                      r_we,        w_we_nxt;
    logic                      r_resp,      w_resp_nxt;
    logic [REQ_W-1:0]          r_resp_data, w_resp_data_nxt;
    logic [CNT_W-1:0]          r_cnt,       w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= '0;
            r_ack       <= 1'b0;
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_resp      <= 1'b0;
            r_resp_data <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_op        <= w_op_nxt;
            r_ack       <= w_ack_nxt;
            r_valid     <= w_valid_nxt;
            r_we        <= w_we_nxt;
            r_resp      <= w_resp_nxt;
            r_resp_data <= w_resp_data_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_op_nxt        = r_op;
        w_ack_nxt       = r_ack;
        w_valid_nxt     = r_valid;
        w_we_nxt        = r_we;
        w_resp_nxt      = r_resp;
        w_resp_data_nxt = r_resp_data;
        w_cnt_nxt       = r_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (w_req_s) begin
                    w_addr_nxt  = dtm_req_data_i[REQ_W-1:A_LSB];
                    w_wdata_nxt = dtm_req_data_i[A_LSB-1:DMI_OP_BITS];
                    w_op_nxt    = dtm_req_data_i[DMI_OP_BITS-1:0];
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACK_WAIT;
                end
            end
            ST_ACK_WAIT: begin
                if (!w_req_s) begin
                    w_ack_nxt = 1'b0;
                    case (r_op)
                        OP_READ, OP_WRITE: begin
                            w_valid_nxt = 1'b1;
                            w_we_nxt    = (r_op == OP_WRITE);
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_ACCESS;
                        end
                        OP_NOP: begin
                            w_resp_data_nxt = {r_addr, {DMI_DATA_BITS{1'b0}}, STS_OK};
                            w_state_nxt     = ST_RESP;
                        end
                        default: begin
                            w_resp_data_nxt = {r_addr, {DMI_DATA_BITS{1'b0}}, STS_FAIL};
                            w_state_nxt     = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ACCESS: begin
                // ready is checked first so it wins over a same-cycle timeout
                if (dmi_ready_i) begin
                    w_valid_nxt     = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_resp_data_nxt = {r_addr,
                                       (r_op == OP_READ) ? dmi_rdata_i : {DMI_DATA_BITS{1'b0}},
                                       dmi_err_i ? STS_FAIL : STS_OK};
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
                        w_valid_nxt     = 1'b0;
                        w_we_nxt        = 1'b0;
                        w_resp_data_nxt = {r_addr, {DMI_DATA_BITS{1'b0}}, STS_FAIL};
                        w_state_nxt     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // first cycle here raises the strobe, so data led it by one edge
                if (!r_resp) begin
                    w_resp_nxt = 1'b1;
                end else if (w_ack_s) begin
                    w_resp_nxt  = 1'b0;
                    w_state_nxt = ST_RESP_DONE;
                end
            end
            ST_RESP_DONE: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dm_ack_o       = r_ack;
    assign dm_resp_o      = r_resp;
    assign dm_resp_data_o = r_resp_data;
    assign dmi_valid_o    = r_valid;
    assign dmi_we_o       = r_we;
    assign dmi_addr_o     = r_addr;
    assign dmi_wdata_o    = r_wdata;

endmodule

// File: tb/tb_dmi_slave.sv
// Directed self-checking bench for dmi_slave with a short bus timeout.
module tb_dmi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        dtm_req_i;
    logic [39:0] dtm_req_data_i;
    logic        dm_ack_o;
    logic        dm_resp_o;
    logic [39:0] dm_resp_data_o;
    logic        dtm_ack_i;
    logic        dmi_valid_o;
    logic        dmi_we_o;
    logic [5:0]  dmi_addr_o;
    logic [31:0] dmi_wdata_o;
    logic        dmi_ready_i;
    logic [31:0] dmi_rdata_i;
    logic        dmi_err_i;

    int n_tests = 0;
    int n_fail  = 0;

    dmi_slave #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .dtm_req_i(dtm_req_i), .dtm_req_data_i(dtm_req_data_i),
        .dm_ack_o(dm_ack_o), .dm_resp_o(dm_resp_o), .dm_resp_data_o(dm_resp_data_o),
        .dtm_ack_i(dtm_ack_i),
        .dmi_valid_o(dmi_valid_o), .dmi_we_o(dmi_we_o), .dmi_addr_o(dmi_addr_o),
        .dmi_wdata_o(dmi_wdata_o), .dmi_ready_i(dmi_ready_i),
        .dmi_rdata_i(dmi_rdata_i), .dmi_err_i(dmi_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_request(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                              output int lat);
        int n;
        dtm_req_data_i = {a, d, op};
        dtm_req_i = 1'b1;
        lat = 0;
        while (!dm_ack_o && lat < 40) begin
            tick();
            lat++;
        end
        check("ack_seen", {63'd0, dm_ack_o}, 64'd1);
        dtm_req_i = 1'b0;
        n = 0;
        while (dm_ack_o && n < 20) begin
            tick();
            n++;
        end
        check("ack_drop", {63'd0, dm_ack_o}, 64'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!dmi_valid_o && n < 20) begin
            tick();
            n++;
        end
        check("valid_seen", {63'd0, dmi_valid_o}, 64'd1);
    endtask

    task automatic finish_resp(input string tag, input logic [39:0] exp, output logic saw_valid);
        int n;
        saw_valid = dmi_valid_o;
        n = 0;
        while (!dm_resp_o && n < 20) begin
            tick();
            n++;
            saw_valid |= dmi_valid_o;
        end
        check({tag, "_resp_seen"}, {63'd0, dm_resp_o}, 64'd1);
        check({tag, "_resp_data"}, {24'd0, dm_resp_data_o}, {24'd0, exp});
        dtm_ack_i = 1'b1;
        n = 0;
        while (dm_resp_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_resp_drop"}, {63'd0, dm_resp_o}, 64'd0);
        dtm_ack_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int          lat;
        int          n;
        logic        sv;
        logic        stable;
        logic [39:0] held;

        rst = 1'b1;
        dtm_req_i = 1'b0;
        dtm_req_data_i = '0;
        dtm_ack_i = 1'b0;
        dmi_ready_i = 1'b0;
        dmi_rdata_i = '0;
        dmi_err_i = 1'b0;
        repeat (3) tick();
        check("rst_outs", {dm_ack_o, dm_resp_o, dmi_valid_o, dmi_we_o, dmi_addr_o, dmi_wdata_o},
              64'd0);
        check("rst_resp_data", {24'd0, dm_resp_data_o}, 64'd0);
        rst = 1'b0;
        tick();

        // read, bus answers after 2 cycles
        do_request(6'h10, 32'h0, 2'd1, lat);
        check("rd_ack_latency", 64'(lat), 64'd3);
        wait_valid();
        check("rd_we", {63'd0, dmi_we_o}, 64'd0);
        check("rd_addr", {58'd0, dmi_addr_o}, 64'h10);
        repeat (2) tick();
        dmi_ready_i = 1'b1;
        dmi_rdata_i = 32'hDEADBEEF;
        tick();
        dmi_ready_i = 1'b0;
        dmi_rdata_i = 32'h0;
        check("rd_valid_drop", {63'd0, dmi_valid_o}, 64'd0);
        finish_resp("rd", {6'h10, 32'hDEADBEEF, 2'd0}, sv);

        // write, single valid pulse
        do_request(6'h04, 32'h80000001, 2'd2, lat);
        wait_valid();
        check("wr_we", {63'd0, dmi_we_o}, 64'd1);
        check("wr_wdata", {32'd0, dmi_wdata_o}, 64'h80000001);
        check("wr_addr", {58'd0, dmi_addr_o}, 64'h04);
        dmi_ready_i = 1'b1;
        dmi_rdata_i = 32'h12345678;
        tick();
        dmi_ready_i = 1'b0;
        check("wr_valid_drop", {63'd0, dmi_valid_o}, 64'd0);
        finish_resp("wr", {6'h04, 32'h0, 2'd0}, sv);
        check("wr_no_second_pulse", {63'd0, sv}, 64'd0);

        // nop and reserved never touch the bus
        do_request(6'h11, 32'hFFFFFFFF, 2'd0, lat);
        finish_resp("nop", {6'h11, 32'h0, 2'd0}, sv);
        check("nop_no_valid", {63'd0, sv}, 64'd0);
        do_request(6'h22, 32'hA5A5A5A5, 2'd3, lat);
        finish_resp("rsv", {6'h22, 32'h0, 2'd2}, sv);
        check("rsv_no_valid", {63'd0, sv}, 64'd0);

        // timeout: valid high for exactly 4 cycles
        do_request(6'h20, 32'h0, 2'd1, lat);
        wait_valid();
        n = 1;
        while (dmi_valid_o && n < 20) begin
            tick();
            if (dmi_valid_o) n++;
        end
        check("to_valid_cycles", 64'(n), 64'd4);
        finish_resp("to", {6'h20, 32'h0, 2'd2}, sv);

        // bus error on a read
        do_request(6'h05, 32'h0, 2'd1, lat);
        wait_valid();
        tick();
        dmi_ready_i = 1'b1;
        dmi_err_i = 1'b1;
        dmi_rdata_i = 32'h0000CAFE;
        tick();
        dmi_ready_i = 1'b0;
        dmi_err_i = 1'b0;
        dmi_rdata_i = 32'h0;
        finish_resp("err", {6'h05, 32'h0000CAFE, 2'd2}, sv);

        // response held while DTM delays its ack; next request waits
        do_request(6'h0A, 32'h0, 2'd0, lat);
        n = 0;
        while (!dm_resp_o && n < 20) begin
            tick();
            n++;
        end
        check("hs_resp_seen", {63'd0, dm_resp_o}, 64'd1);
        held = dm_resp_data_o;
        check("hs_resp_data", {24'd0, held}, {24'd0, 6'h0A, 32'h0, 2'd0});
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!dm_resp_o || dm_resp_data_o !== held) stable = 1'b0;
        end
        dtm_req_data_i = {6'h3F, 32'h0, 2'd0};
        dtm_req_i = 1'b1;
        repeat (5) begin
            tick();
            if (!dm_resp_o || dm_resp_data_o !== held || dm_ack_o) stable = 1'b0;
        end
        check("hs_stable_pending", {63'd0, stable}, 64'd1);
        dtm_ack_i = 1'b1;
        n = 0;
        while (dm_resp_o && n < 20) begin
            tick();
            n++;
            if (dm_ack_o) stable = 1'b0;
        end
        check("hs_resp_drop", {63'd0, dm_resp_o}, 64'd0);
        check("hs_no_early_ack", {63'd0, stable}, 64'd1);
        check("hs_data_held_done", {24'd0, dm_resp_data_o}, {24'd0, held});
        dtm_ack_i = 1'b0;
        lat = 0;
        while (!dm_ack_o && lat < 40) begin
            tick();
            lat++;
        end
        check("hs_second_ack_latency", 64'(lat), 64'd4);
        dtm_req_i = 1'b0;
        finish_resp("hs2", {6'h3F, 32'h0, 2'd0}, sv);

        // reset in the middle of an access
        do_request(6'h30, 32'h0, 2'd1, lat);
        wait_valid();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_outs",
              {dm_ack_o, dm_resp_o, dmi_valid_o, dmi_we_o, dmi_addr_o, dmi_wdata_o}, 64'd0);
        check("mid_rst_resp_data", {24'd0, dm_resp_data_o}, 64'd0);
        rst = 1'b0;
        tick();
        do_request(6'h31, 32'h0, 2'd1, lat);
        check("post_rst_ack_latency", 64'(lat), 64'd3);
        wait_valid();
        check("post_rst_addr", {58'd0, dmi_addr_o}, 64'h31);
        dmi_ready_i = 1'b1;
        dmi_rdata_i = 32'h01234567;
        tick();
        dmi_ready_i = 1'b0;
        dmi_rdata_i = 32'h0;
        finish_resp("post_rst", {6'h31, 32'h01234567, 2'd0}, sv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
